id_ex_stage: RTL

Decode-to-execute pipeline register of the 16-bit pipelined CPU. It sits directly upstream of the ALU and drives the ALU's `operation`, `readData0` and `readData1` inputs. It latches the decoded instruction and its operands, and selects immediate versus register operands. It forwards results from the EX/MEM and MEM/WB stages, detects load-use hazards (stalling decode and inserting a bubble), and squashes the decode slot on flush.

---
 rtl/id_ex_stage.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register: latches the decoded instruction, bypasses
// write-back results into the operands, forwards EX/MEM and MEM/WB results, and stalls on load-use hazards.
module id_ex_stage #(
  parameter int REG_ADDR_W = 4,
  parameter int DATA_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [3:0]            id_operation,
  input  logic [REG_ADDR_W-1:0] id_rs0,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_regWrite,
  input  logic                  id_memRead,
  input  logic                  id_useImm,
  input  logic [DATA_W-1:0]     id_data0,
  input  logic [DATA_W-1:0]     id_data1,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic                  flush,
  input  logic                  exmem_regWrite,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic [DATA_W-1:0]     exmem_result,
  input  logic                  memwb_regWrite,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic [DATA_W-1:0]     memwb_result,
  output logic                  stall,
  output logic                  ex_valid,
  output logic [3:0]            operation,
  output logic [DATA_W-1:0]     readData0,
  output logic [DATA_W-1:0]     readData1,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  ex_regWrite,
  output logic                  ex_memRead
);

  logic                  valid_q, valid_d;
  logic [3:0]            operation_q, operation_d;
  logic [REG_ADDR_W-1:0] rs0_q, rs0_d;
  logic [REG_ADDR_W-1:0] rs1_q, rs1_d;
  logic                  fwd1_en_q, fwd1_en_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  reg_write_q, reg_write_d;
  logic                  mem_read_q, mem_read_d;
  logic [DATA_W-1:0]     op0_q, op0_d;
  logic [DATA_W-1:0]     op1_q, op1_d;

  logic                  hazard_rs0, hazard_rs1;
  logic [DATA_W-1:0]     cap0, cap1;

  // A load in EX whose destination feeds the decode slot cannot be forwarded in time.
  assign hazard_rs0 = (rd_q == id_rs0);
  assign hazard_rs1 = !id_useImm && (rd_q == id_rs1);
  assign stall = valid_q && mem_read_q && (rd_q != '0) && id_valid && !flush &&
                 (hazard_rs0 || hazard_rs1);

  // Capture-time bypass covers the write-back that lands in the register file this same edge.
  always_comb begin
    cap0 = id_data0;
    if (id_rs0 == '0) begin
      cap0 = '0;
    end else if (memwb_regWrite && (memwb_rd == id_rs0)) begin
      cap0 = memwb_result;
    end
    cap1 = id_data1;
    if (id_useImm) begin
      cap1 = id_imm;
    end else if (id_rs1 == '0) begin
      cap1 = '0;
    end else if (memwb_regWrite && (memwb_rd == id_rs1)) begin
      cap1 = memwb_result;
    end
  end

  always_comb begin
    valid_d     = 1'b0;
    operation_d = '0;
    rs0_d       = '0;
    rs1_d       = '0;
    fwd1_en_d   = 1'b0;
    rd_d        = '0;
    reg_write_d = 1'b0;
    mem_read_d  = 1'b0;
    op0_d       = '0;
    op1_d       = '0;
    if (!flush && !stall && id_valid) begin
      valid_d     = 1'b1;
      operation_d = id_operation;
      rs0_d       = id_rs0;
      rs1_d       = id_rs1;
      fwd1_en_d   = !id_useImm;
      rd_d        = id_rd;
      reg_write_d = id_regWrite;
      mem_read_d  = id_memRead;
      op0_d       = cap0;
      op1_d       = cap1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= 1'b0;
      operation_q <= '0;
      rs0_q       <= '0;
      rs1_q       <= '0;
      fwd1_en_q   <= 1'b0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      op0_q       <= '0;
      op1_q       <= '0;
    end else begin
      valid_q     <= valid_d;
      operation_q <= operation_d;
      rs0_q       <= rs0_d;
      rs1_q       <= rs1_d;
      fwd1_en_q   <= fwd1_en_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      op0_q       <= op0_d;
      op1_q       <= op1_d;
    end
  end

  // EX/MEM is the younger result, so it wins over MEM/WB for the same register.
  always_comb begin
    readData0 = op0_q;
    if (rs0_q != '0) begin
      if (exmem_regWrite && (exmem_rd == rs0_q)) begin
        readData0 = exmem_result;
      end else if (memwb_regWrite && (memwb_rd == rs0_q)) begin
        readData0 = memwb_result;
      end
    end
    readData1 = op1_q;
    if (fwd1_en_q && (rs1_q != '0)) begin
      if (exmem_regWrite && (exmem_rd == rs1_q)) begin
        readData1 = exmem_result;
      end else if (memwb_regWrite && (memwb_rd == rs1_q)) begin
        readData1 = memwb_result;
      end
    end
  end

  assign ex_valid    = valid_q;
  assign operation   = operation_q;
  assign ex_rd       = rd_q;
  assign ex_regWrite = reg_write_q;
  assign ex_memRead  = mem_read_q;

endmodule
